prio_arbiter_rr: RTL and testbench
==================================

// Module: prio_arbiter_rr
// PURPOSE
//  Parametrised successor to the 8:3 priority encoder. Takes N request lines and picks one
//  winner in either fixed-priority mode (highest index wins) or round-robin mode. The winner
//  is presented as a registered index plus one-hot grant on a valid/ready handshake.
//  Feeds shared-resource arbitration (bus, FIFO write port) in the datapath.
// PARAMETERS
//  N      8              number of request lines, 2..64
//  W      $clog2(N)      index width (localparam, derived, not overridable)
// PORTS
//  clk    in   1   clock, all state on rising edge
//  rst_n  in   1   asynchronous active-low reset
//  en     in   1   arbitration enable; 0 = no new grants issued
//  mode   in   1   0 = fixed priority (index N-1 highest), 1 = round-robin
//  req    in   N   request lines, level sensitive
//  ready  in   1   consumer accepts current grant this cycle
//  valid  out  1   grant outstanding
//  q      out  W   winning index; 0 when valid=0
//  gnt    out  N   one-hot of q; all-zero when valid=0
// BEHAVIOUR
//  - Reset (async assert, sync release): valid=0, q=0, gnt=0, ptr=0, state=IDLE.
//  - ptr (W bits, internal) = last index granted in RR mode. RR search order: ptr-1, ptr-2,
//    ..., 0, N-1, ..., ptr (descending, wrapping). With ptr=0 order is N-1..0, i.e. identical
//    to fixed priority. Fixed mode always searches N-1..0 and ignores ptr.
//  - States: IDLE (valid=0), GRANT (valid=1).
//  - IDLE: if en && |req, winner registered; next cycle valid=1, q/gnt = winner (latency 1).
//    Otherwise stay IDLE.
//  - GRANT: q/gnt/valid held stable while ready=0, regardless of req, en or mode changes
//    (grant is sticky; requester dropping req does not revoke it).
//  - Handshake = valid && ready. On handshake: if mode=1, ptr<=q; ptr unchanged in mode 0.
//    Same cycle, if en && |req: new winner computed with the updated pointer (ptr'=q in
//    RR) and registered; valid stays 1 (back-to-back, one grant per cycle at full rate).
//    Else -> IDLE, valid=0 next cycle.
//  - en=0 during GRANT: outstanding grant still held until accepted; no new grant after it.
//  - mode sampled only at arbitration instants (IDLE pick or handshake re-pick).
//  - Index arithmetic modulo N (N need not be power of 2): ptr-1 at ptr=0 wraps to N-1.
//  - req all-zero at arbitration -> no grant, valid=0; q never X.
//  - Reset mid-GRANT: grant dropped immediately, ptr back to 0.
// STRUCTURE
//  - Shared package prio_arb_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1, default N, clog2 helper.
//  - Sub-module prio_pick (combinational): inputs req[N], start index, mode; outputs
//    found, idx[W]. Implemented via double-width rotate + MSB-first priority scan.
//  - Top: 2-state FSM, ptr register, output registers; gnt decoded from registered q.
// TESTING
//  1 Reset: rst_n=0 with req=all-ones -> valid=0, q=0, gnt=0 throughout and 1 cycle after.
//  2 Fixed: mode=0, en=1, req=8'b1010_0100, ready=1 -> next cycle valid=1, q=7, gnt=8'h80;
//    continues q=7 each cycle while req unchanged.
//  3 Hold: grant q=5 pending, ready=0 for 3 cycles, req changes to 8'h01 -> q stays 5,
//    gnt=8'h20; ready=1 -> next cycle q=0.
//  4 RR: mode=1, req=8'hFF, ready=1 -> q sequence 7,6,5,4,3,2,1,0,7 on consecutive cycles.
//  5 Enable/empty: en=0 with req=8'hFF -> valid stays 0; en=1, req=0 -> valid stays 0;
//    en dropped during pending grant -> grant still accepted, then valid=0.
//  6 N=5, mode=1, req=5'b1_0001 -> alternating q=4,0,4,0; reset mid-grant -> valid=0 same
//    cycle, first post-reset grant q=4.

Source files
------------

// File: rtl/prio_arbiter_rr_pkg.sv
// rtl/prio_arbiter_rr_pkg.sv - shared types, mode encodings and index-width helper for the arbiter
package prio_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;
    localparam int   DEFAULT_N  = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // Index width for n request lines; never below 1 so ports stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/prio_arbiter_rr_if.sv
// rtl/prio_arbiter_rr_if.sv - request/grant handshake bundle between requesters and the arbiter
interface prio_arbiter_rr_if
    import prio_arb_pkg::*;
#(
    parameter int N = DEFAULT_N
);
    localparam int W = clog2(N);

    logic         en;
    logic         mode;
    logic [N-1:0] req;
    logic         ready;
    logic         valid;
    logic [W-1:0] q;
    logic [N-1:0] gnt;

    modport master (output en, mode, req, ready, input valid, q, gnt);
    modport slave  (input en, mode, req, ready, output valid, q, gnt);

endinterface

// File: rtl/prio_arbiter_rr_pick.sv
// rtl/prio_arbiter_rr_pick.sv - combinational winner search, descending from i_ptr-1 with wrap
module prio_pick
    import prio_arb_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [N-1:0]         i_req,
    input  logic [clog2(N)-1:0]  i_ptr,
    input  logic                 i_mode,
    output logic                 o_found,
    output logic [clog2(N)-1:0]  o_idx
);
    localparam int         W  = clog2(N);
    localparam logic [W:0] NW = (W + 1)'(N);

    logic [W-1:0] w_base;
    logic [N-1:0] w_rot;
    logic [W-1:0] w_hit;
    logic [W:0]   w_sum;

    // Rotating the doubled vector right by base puts request (base+k) mod N at bit k,
    // so the topmost set bit is the first hit in the order base-1, ..., 0, N-1, ..., base.
    assign w_base = (i_mode == MODE_FIXED) ? '0 : i_ptr;
    assign w_rot  = N'({i_req, i_req} >> w_base);

    always_comb begin
        w_hit = '0;
        for (int k = 0; k < N; k++) begin
            if (w_rot[k]) w_hit = W'(k);
        end
    end

    assign w_sum   = {1'b0, w_base} + {1'b0, w_hit};
    assign o_found = |w_rot;

    always_comb begin
        o_idx = '0;
        if (o_found) o_idx = (w_sum >= NW) ? W'(w_sum - NW) : w_sum[W-1:0];
    end

endmodule

// File: rtl/prio_arbiter_rr.sv
// rtl/prio_arbiter_rr.sv - N-way fixed/round-robin arbiter with registered index and one-hot grant
module prio_arbiter_rr
    import prio_arb_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic              clk,
    input  logic              rst_n,
    prio_arbiter_rr_if.slave  bus
);
    localparam int W = clog2(N);

    arb_state_t   r_state;
    arb_state_t   w_state_nxt;
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_ptr_nxt;
    logic [W-1:0] r_q;
    logic [W-1:0] w_pick_ptr;
    logic [W-1:0] w_idx;
    logic         w_found;
    logic         w_load;
    logic         w_hs;

    assign w_hs = (r_state == ST_GRANT) && bus.ready;

    // A re-pick only happens on a handshake, where the pointer is about to become r_q.
    assign w_pick_ptr = (r_state == ST_GRANT && bus.mode == MODE_RR) ? r_q : r_ptr;

    prio_pick #(.N(N)) u_pick (
        .i_req   (bus.req),
        .i_ptr   (w_pick_ptr),
        .i_mode  (bus.mode),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.en && w_found) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_hs) begin
                    if (bus.mode == MODE_RR) w_ptr_nxt = r_q;
                    if (bus.en && w_found) w_load = 1'b1;
                    else                   w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_load)                      r_q <= w_idx;
            else if (w_state_nxt == ST_IDLE) r_q <= '0;
        end
    end

    assign bus.valid = (r_state == ST_GRANT);
    assign bus.q     = r_q;
    assign bus.gnt   = (r_state == ST_GRANT) ? (N'(1) << r_q) : '0;

endmodule

// File: tb/tb_prio_arbiter_rr.sv
// tb/tb_prio_arbiter_rr.sv - directed self-checking bench for prio_arbiter_rr at N=8 and N=5
module tb_prio_arbiter_rr;

    logic clk;
    logic rst_n;
    logic rst5_n;
    int   n_pass;
    int   n_total;

    prio_arbiter_rr_if #(.N(8)) bus8 ();
    prio_arbiter_rr_if #(.N(5)) bus5 ();

    prio_arbiter_rr #(.N(8)) u_dut8 (.clk(clk), .rst_n(rst_n),  .bus(bus8));
    prio_arbiter_rr #(.N(5)) u_dut5 (.clk(clk), .rst_n(rst5_n), .bus(bus5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk8(input string tag, input logic v, input logic [2:0] q, input logic [7:0] g);
        chk({tag, ".valid"}, 64'(bus8.valid), 64'(v));
        chk({tag, ".q"},     64'(bus8.q),     64'(q));
        chk({tag, ".gnt"},   64'(bus8.gnt),   64'(g));
    endtask

    task automatic chk5(input string tag, input logic v, input logic [2:0] q, input logic [4:0] g);
        chk({tag, ".valid"}, 64'(bus5.valid), 64'(v));
        chk({tag, ".q"},     64'(bus5.q),     64'(q));
        chk({tag, ".gnt"},   64'(bus5.gnt),   64'(g));
    endtask

    initial begin
        logic [2:0] rr_seq [9];
        rr_seq  = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        n_pass  = 0;
        n_total = 0;

        rst_n      = 1'b0;
        rst5_n     = 1'b0;
        bus8.en    = 1'b1;
        bus8.mode  = 1'b0;
        bus8.req   = 8'hFF;
        bus8.ready = 1'b1;
        bus5.en    = 1'b0;
        bus5.mode  = 1'b1;
        bus5.req   = 5'h00;
        bus5.ready = 1'b1;

        // Reset held with every line requesting
        @(negedge clk); chk8("rst0", 1'b0, 3'd0, 8'h00);
        @(negedge clk); chk8("rst1", 1'b0, 3'd0, 8'h00);
        bus8.req = 8'h00;
        rst_n    = 1'b1;
        @(negedge clk); chk8("rst_after", 1'b0, 3'd0, 8'h00);

        // Fixed priority: highest index wins, repeated each handshake
        bus8.req = 8'b1010_0100;
        @(negedge clk); chk8("fix0", 1'b1, 3'd7, 8'h80);
        @(negedge clk); chk8("fix1", 1'b1, 3'd7, 8'h80);
        @(negedge clk); chk8("fix2", 1'b1, 3'd7, 8'h80);

        // Sticky grant while ready is low
        bus8.req = 8'h24;
        @(negedge clk); chk8("hold_pick", 1'b1, 3'd5, 8'h20);
        bus8.ready = 1'b0;
        bus8.req   = 8'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk8("hold", 1'b1, 3'd5, 8'h20);
        end
        bus8.ready = 1'b1;
        @(negedge clk); chk8("hold_rel", 1'b1, 3'd0, 8'h01);

        // Round-robin rotation with all lines requesting
        bus8.mode = 1'b1;
        bus8.req  = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk); chk8("rr", 1'b1, rr_seq[i], 8'h01 << rr_seq[i]);
        end

        // Enable low and empty requests issue nothing
        bus8.en = 1'b0;
        @(negedge clk); chk8("en0_accept", 1'b0, 3'd0, 8'h00);
        @(negedge clk); chk8("en0_idle", 1'b0, 3'd0, 8'h00);
        bus8.en  = 1'b1;
        bus8.req = 8'h00;
        @(negedge clk); chk8("empty0", 1'b0, 3'd0, 8'h00);
        @(negedge clk); chk8("empty1", 1'b0, 3'd0, 8'h00);

        // Enable dropped while a grant is pending
        bus8.mode  = 1'b0;
        bus8.req   = 8'h10;
        bus8.ready = 1'b0;
        @(negedge clk); chk8("pend_pick", 1'b1, 3'd4, 8'h10);
        bus8.en = 1'b0;
        @(negedge clk); chk8("pend_hold", 1'b1, 3'd4, 8'h10);
        bus8.ready = 1'b1;
        @(negedge clk); chk8("pend_done", 1'b0, 3'd0, 8'h00);

        // N=5: modulo wrap alternates between the two requesters
        bus5.en  = 1'b1;
        bus5.req = 5'b1_0001;
        rst5_n   = 1'b1;
        @(negedge clk); chk5("n5_a", 1'b1, 3'd4, 5'h10);
        @(negedge clk); chk5("n5_b", 1'b1, 3'd0, 5'h01);
        @(negedge clk); chk5("n5_c", 1'b1, 3'd4, 5'h10);
        @(negedge clk); chk5("n5_d", 1'b1, 3'd0, 5'h01);

        // Asynchronous reset mid-grant, pointer returns to 0
        #2 rst5_n = 1'b0;
        #1 chk5("n5_rst", 1'b0, 3'd0, 5'h00);
        @(negedge clk);
        rst5_n = 1'b1;
        @(negedge clk); chk5("n5_post", 1'b1, 3'd4, 5'h10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
